// File: rtl/filter_event_controller.sv
// filter_event_controller
//   Sequences readout of a trapezoidal shaping filter. The controller arms on
//   a signed threshold crossing. It then tracks the peak amplitude over a
//   fixed search window and waits out a dead time. After that it presents
//   {energy, timestamp, pileup} on a valid/ready handshake.
//
//   Optional feature: define BASELINE_EN to subtract a running baseline
//   average (2^BL_SHIFT samples) from the reported energy. When BASELINE_EN
//   is not defined, no baseline logic is built and the energy is the raw peak.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high
//   enable       run enable; low parks the controller in IDLE
//   threshold    signed trigger level
//   filter_data  signed filter sample, one per clk
//   event_ready  downstream accept
//   event_valid  event record valid (REPORT state)
//   event_energy signed peak amplitude (baseline-subtracted with BASELINE_EN)
//   event_ts     timestamp of the trigger sample
//   event_pileup second crossing seen during PEAK or DEAD
//   drop_count   crossings lost while in REPORT, saturating
//   busy         high in PEAK, DEAD, REPORT
module filter_event_controller #(
  parameter int DATA_W   = 16,
  parameter int TS_W     = 32,
  parameter int PEAK_WIN = 8,
  parameter int DEAD_CYC = 4,
  parameter int BL_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] filter_data,
  input  logic              event_ready,
  output logic              event_valid,
  output logic [DATA_W-1:0] event_energy,
  output logic [TS_W-1:0]   event_ts,
  output logic              event_pileup,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int CNT_MAX = (PEAK_WIN - 1 > DEAD_CYC) ? PEAK_WIN - 1 : DEAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ARMED, PEAK, DEAD, REPORT} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [TS_W-1:0]           ts_cnt_reg;
  logic signed [DATA_W-1:0]  prev_reg;
  logic signed [DATA_W-1:0]  thr_reg;
  logic signed [DATA_W-1:0]  max_reg;
  logic [TS_W-1:0]           ts_reg;
  logic                      pileup_reg;
  logic [15:0]               drop_reg;

  logic signed [DATA_W-1:0]  data_s;
  logic signed [DATA_W-1:0]  active_thr;
  logic                      crossing;
  logic                      capture;

  assign data_s = $signed(filter_data);

  // The live threshold is used only while armed. Outside ARMED, pile-up and
  // drop detection keep using the level that was in force when armed.
  assign active_thr = (state_reg == ARMED) ? $signed(threshold) : thr_reg;
  assign crossing   = (data_s > active_thr) && (prev_reg <= active_thr);
  assign capture    = (state_reg == ARMED) && enable && crossing;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (crossing) begin
          state_next = PEAK;
          cnt_next   = '0;
        end
      end
      PEAK: begin
        // The trigger sample was handled in ARMED, so PEAK covers the
        // remaining PEAK_WIN-1 samples of the window.
        if (cnt_reg == CNT_W'(PEAK_WIN - 2)) begin
          state_next = DEAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DEAD: begin
        if (cnt_reg == CNT_W'(DEAD_CYC - 1)) begin
          state_next = REPORT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      REPORT: begin
        if (event_ready) state_next = enable ? ARMED : IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      ts_cnt_reg <= '0;
      prev_reg   <= '0;
      thr_reg    <= '0;
      max_reg    <= '0;
      ts_reg     <= '0;
      pileup_reg <= 1'b0;
      drop_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
      prev_reg   <= data_s;
      if (state_reg == ARMED) thr_reg <= $signed(threshold);

      if (capture) begin
        ts_reg     <= ts_cnt_reg;
        max_reg    <= data_s;
        pileup_reg <= 1'b0;
      end else if (state_reg == PEAK) begin
        if (data_s > max_reg) max_reg <= data_s;
        if (crossing) pileup_reg <= 1'b1;
      end else if (state_reg == DEAD) begin
        if (crossing) pileup_reg <= 1'b1;
      end

      if ((state_reg == REPORT) && crossing && (drop_reg != 16'hFFFF))
        drop_reg <= drop_reg + 16'd1;
    end
  end

`ifdef BASELINE_EN
  localparam int BL_LEN = 1 << BL_SHIFT;
  localparam int SUM_W  = DATA_W + BL_SHIFT;

  logic signed [DATA_W-1:0] win_reg [BL_LEN];
  logic signed [SUM_W-1:0]  sum_reg;
  logic [BL_SHIFT:0]        seen_reg;
  logic signed [DATA_W-1:0] baseline_reg;
  logic signed [DATA_W:0]   diff;

  // The running window always tracks the input. Only the baseline register
  // is frozen while an event is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BL_LEN; i++) win_reg[i] <= '0;
      sum_reg      <= '0;
      seen_reg     <= '0;
      baseline_reg <= '0;
    end else begin
      win_reg[0] <= data_s;
      for (int i = 1; i < BL_LEN; i++) win_reg[i] <= win_reg[i-1];
      sum_reg <= sum_reg + SUM_W'(data_s) - SUM_W'(win_reg[BL_LEN-1]);
      if (seen_reg != (BL_SHIFT + 1)'(BL_LEN)) seen_reg <= seen_reg + 1'b1;
      if ((state_reg == ARMED) && !capture)
        baseline_reg <= (seen_reg == (BL_SHIFT + 1)'(BL_LEN)) ?
                        DATA_W'(sum_reg >>> BL_SHIFT) : '0;
    end
  end

  // One extra bit catches overflow of the subtraction. The result then
  // clamps to the signed DATA_W range.
  assign diff = (DATA_W + 1)'(max_reg) - (DATA_W + 1)'(baseline_reg);

  always_comb begin
    event_energy = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1])
      event_energy = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign event_energy = max_reg;
`endif

  assign event_valid  = (state_reg == REPORT);
  assign busy         = (state_reg == PEAK) || (state_reg == DEAD) ||
                        (state_reg == REPORT);
  assign event_ts     = ts_reg;
  assign event_pileup = pileup_reg;
  assign drop_count   = drop_reg;

endmodule

// File: tb/tb_filter_event_controller.sv
// Testbench for filter_event_controller
// (DATA_W=16, PEAK_WIN=8, DEAD_CYC=4, threshold=100).
// When stimulus is driven, the expected event records go into a scoreboard
// queue. A negedge monitor compares every valid cycle against the head of
// the queue and pops the head on handshake.
module tb_filter_event_controller;
  localparam int LAT = 12;  // PEAK_WIN + DEAD_CYC

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] threshold = 16'd100;
  logic [15:0] filter_data = 16'd0;
  logic        event_ready = 1'b0;
  logic        event_valid;
  logic [15:0] event_energy;
  logic [31:0] event_ts;
  logic        event_pileup;
  logic [15:0] drop_count;
  logic        busy;

  filter_event_controller #(
    .DATA_W(16), .TS_W(32), .PEAK_WIN(8), .DEAD_CYC(4), .BL_SHIFT(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
    .filter_data(filter_data), .event_ready(event_ready),
    .event_valid(event_valid), .event_energy(event_energy),
    .event_ts(event_ts), .event_pileup(event_pileup),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] energy;
    logic [31:0] ts;
    logic        pileup;
    int          vcyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [31:0] ts_model = 32'd0;
  logic valid_d = 1'b0;

  // Reference timestamp: free-running from reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) ts_model <= 32'd0;
    else       ts_model <= ts_model + 32'd1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (event_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: cyc=%0d energy=%0d ts=%0d required no valid",
                 cyc, $signed(event_energy), event_ts);
      end else begin
        if (event_energy !== sb[0].energy || event_ts !== sb[0].ts ||
            event_pileup !== sb[0].pileup) begin
          failures++;
          $display("FAIL event_fields: got energy=%0d ts=%0d pileup=%0b required energy=%0d ts=%0d pileup=%0b",
                   $signed(event_energy), event_ts, event_pileup,
                   $signed(sb[0].energy), sb[0].ts, sb[0].pileup);
        end
        if (!valid_d) begin
          checks++;
          if (cyc !== sb[0].vcyc) begin
            failures++;
            $display("FAIL valid_latency: first valid at cyc=%0d required cyc=%0d", cyc, sb[0].vcyc);
          end
        end
        if (event_ready) begin
          $display("event accepted: cyc=%0d energy=%0d ts=%0d pileup=%0b",
                   cyc, $signed(event_energy), event_ts, event_pileup);
          void'(sb.pop_front());
        end
      end
    end
    valid_d <= event_valid;
  end

  // Advance one clock and present a new sample and ready level.
  task automatic step(input logic [15:0] d, input logic r);
    @(posedge clk);
    #1;
    filter_data = d;
    event_ready = r;
  endtask

  // Call this right after the crossing sample has been stepped in.
  task automatic push_exp(input logic [15:0] e, input logic p);
    exp_t x;
    x.energy = e;
    x.ts     = ts_model;
    x.pileup = p;
    x.vcyc   = cyc + LAT;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({event_valid, event_energy, event_ts, event_pileup, drop_count, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b energy=%0h ts=%0h pileup=%0b drop=%0d busy=%0b required all 0",
               event_valid, event_energy, event_ts, event_pileup, drop_count, busy);
    end
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) step(16'd0, 1'b1);
  endtask

  task automatic test_single;
    logic [15:0] s [10];
    s = '{16'd0, 16'd150, 16'd300, 16'd450, 16'd400, 16'd300, 16'd200, 16'd100, 16'd50, 16'd0};
    for (int i = 0; i < 10; i++) begin
      step(s[i], 1'b1);
      if (i == 1) push_exp(16'd450, 1'b0);
      if (i == 2) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_in_peak: got %0b required 1", busy);
        end
      end
    end
    repeat (8) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL single_drained: %0d events pending required 0", sb.size());
    end
  endtask

  task automatic test_pileup;
    logic [15:0] s [12];
    s = '{16'd0, 16'd150, 16'd300, 16'd450, 16'd400, 16'd300, 16'd200, 16'd100,
          16'd50, 16'd0, 16'd200, 16'd0};
    for (int i = 0; i < 12; i++) begin
      step(s[i], 1'b1);
      if (i == 1) push_exp(16'd450, 1'b1);
    end
    repeat (8) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pileup_drained: %0d events pending required 0", sb.size());
    end
  endtask

  task automatic test_hold_ready;
    logic [15:0] s [10];
    s = '{16'd0, 16'd150, 16'd300, 16'd450, 16'd400, 16'd300, 16'd200, 16'd100, 16'd50, 16'd0};
    for (int i = 0; i < 10; i++) begin
      step(s[i], 1'b0);
      if (i == 1) push_exp(16'd450, 1'b0);
    end
    repeat (4) step(16'd0, 1'b0);   // reaches T+12, valid now high
    for (int i = 0; i < 19; i++)     // T+13 .. T+31, three crossings
      step((i < 6 && i % 2 == 0) ? 16'd200 : 16'd0, 1'b0);
    checks++;
    if (event_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_valid: got %0b required 1 while ready low", event_valid);
    end
    step(16'd0, 1'b1);              // accepted on first ready
    step(16'd0, 1'b1);
    checks++;
    if (drop_count !== 16'd3) begin
      failures++;
      $display("FAIL drop_count: got %0d required 3", drop_count);
    end
    checks++;
    if (event_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL hold_accept: valid=%0b pending=%0d required valid=0 pending=0",
               event_valid, sb.size());
    end
    repeat (2) step(16'd0, 1'b1);
  endtask

  task automatic test_disable_in_peak;
    int seen;
    logic [15:0] s [10];
    s = '{16'd0, 16'd150, 16'd300, 16'd450, 16'd400, 16'd300, 16'd200, 16'd100, 16'd50, 16'd0};
    for (int i = 0; i < 10; i++) begin
      step(s[i], 1'b1);
      if (i == 1) push_exp(16'd450, 1'b0);
      if (i == 4) enable = 1'b0;
    end
    repeat (8) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL disable_report: pending=%0d busy=%0b required pending=0 busy=0",
               sb.size(), busy);
    end
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      step((i < 10) ? s[i] : 16'd0, 1'b1);
      if (event_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL idle_no_event: %0d active cycles required 0", seen);
    end
    enable = 1'b1;
    repeat (3) step(16'd0, 1'b1);
  endtask

  task automatic test_reset_mid_event;
    logic [15:0] s [7];
    s = '{16'd0, 16'd150, 16'd300, 16'd450, 16'd400, 16'd300, 16'd200};
    for (int i = 0; i < 7; i++) begin
      step(s[i], 1'b1);
      if (i == 6) reset = 1'b1;     // asserted during cycle T+5
    end
    step(16'd0, 1'b1);
    step(16'd0, 1'b1);
    checks++;
    if (event_valid !== 1'b0 || drop_count !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_event: valid=%0b drop=%0d busy=%0b required 0 0 0",
               event_valid, drop_count, busy);
    end
    reset = 1'b0;
    repeat (20) step(16'd0, 1'b1);
    checks++;
    if (drop_count !== 16'd0) begin
      failures++;
      $display("FAIL drop_after_reset: got %0d required 0", drop_count);
    end
    // a new pulse after release reports normally with the restarted timestamp
    for (int i = 0; i < 7; i++) begin
      step(s[i], 1'b1);
      if (i == 1) push_exp(16'd450, 1'b0);
    end
    repeat (14) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL post_reset_event: %0d events pending required 0", sb.size());
    end
  endtask

  task automatic test_signed;
    logic [15:0] s [8];
    s = '{16'hFF38, 16'hFF38, 16'hFF38, 16'hFFCE, 16'hFFF6, 16'hFFB0, 16'hFF6A, 16'hFF38};
    threshold = 16'hFF9C;  // -100
    for (int i = 0; i < 8; i++) begin
      step(s[i], 1'b1);
      if (i == 3) push_exp(16'hFFF6, 1'b0);  // peak -10
    end
    repeat (14) step(16'hFF38, 1'b1);
    step(16'd0, 1'b1);
    threshold = 16'd100;
    repeat (3) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL signed_drained: %0d events pending required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s [18];
    s = '{16'd0, 16'd150, 16'd300, 16'd450, 16'd400, 16'd300, 16'd200, 16'd100, 16'd50,
          16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd250, 16'd500, 16'd100, 16'd0};
    for (int i = 0; i < 18; i++) begin
      step(s[i], 1'b1);
      if (i == 1)  push_exp(16'd450, 1'b0);
      if (i == 14) push_exp(16'd500, 1'b0);  // first ARMED cycle after accept
    end
    repeat (14) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: %0d events pending required 0", sb.size());
    end
  endtask

`ifdef BASELINE_EN
  task automatic test_baseline;
    logic [15:0] s [6];
    s = '{16'd150, 16'd300, 16'd450, 16'd300, 16'd100, 16'd50};
    repeat (32) step(16'd50, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(s[i], 1'b1);
      if (i == 0) push_exp(16'd400, 1'b0);
    end
    repeat (10) step(16'd50, 1'b1);
    repeat (20) step(16'd0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL baseline_drained: %0d events pending required 0", sb.size());
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef BASELINE_EN
    test_baseline;
`else
    test_single;
    test_pileup;
    test_hold_ready;
    test_disable_in_peak;
    test_reset_mid_event;
    test_signed;
    test_back_to_back;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cyc=%0d required completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
